// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/load-store memory port arbiter: FSM states,
// requester ownership encoding and latency counter sizing.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester alternating-priority grant. The priority bit names the
// requester that wins a tie and flips to the loser after every granted cycle.
module rr_arb2
  import mem_port_arbiter_pkg::*;
#(
  parameter logic RST_PRIO = logic'(OWN_D)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       upd_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic prio_q;
  logic prio_d;

  // grant selection from requests and priority
  always_comb begin
    gnt_o = 2'b00;
    if (!en_i) begin
      gnt_o = 2'b00;
    end else if (req_i == 2'b11) begin
      gnt_o = prio_q ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
  end

  // priority moves to the requester that did not win
  always_comb begin
    prio_d = prio_q;
    if (upd_i && (gnt_o != 2'b00)) begin
      prio_d = gnt_o[0];
    end else begin
      prio_d = prio_q;
    end
  end

  // priority register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_q <= RST_PRIO;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// load/store, one access in flight, with alternating priority under contention.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                killed_q;
  logic                accept_s;
  logic                hs_s;
  logic [1:0]          gnt_s;

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign accept_s = rst_n && ((state_q == IDLE) || (state_q == RESP));
  assign hs_s     = |gnt_s;

  rr_arb2 #(.RST_PRIO(logic'(OWN_D))) u_arb (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (accept_s),
    .upd_i  (hs_s),
    .req_i  ({d_req_valid, if_req_valid}),
    .gnt_o  (gnt_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: state_d = hs_s ? ISSUE : IDLE;
      ISSUE:      state_d = (|wstrb_q) ? RESP : WAIT;
      WAIT:       state_d = (cnt_q == CNT_W'(1)) ? RESP : WAIT;
      default:    state_d = IDLE;
    endcase
  end

  // request capture, latency countdown, read sample and fetch-kill tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q  <= OWN_IF;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      killed_q <= 1'b0;
    end else begin
      if (hs_s) begin
        owner_q  <= gnt_s[1] ? OWN_D : OWN_IF;
        addr_q   <= gnt_s[1] ? d_addr : if_addr;
        wdata_q  <= gnt_s[1] ? d_wdata : '0;
        wstrb_q  <= gnt_s[1] ? d_wstrb : '0;
        killed_q <= 1'b0;
      end
      if (state_q == ISSUE) begin
        cnt_q   <= CNT_W'(MEM_LATENCY);
        rdata_q <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rdata_q <= mem_rdata;
        end
      end
      // A kill in the RESP cycle itself is handled combinationally below.
      if (((state_q == ISSUE) || (state_q == WAIT)) && (owner_q == OWN_IF) && if_kill) begin
        killed_q <= 1'b1;
      end
    end
  end

  // outputs
  always_comb begin
    if_req_ready  = gnt_s[0];
    d_req_ready   = gnt_s[1];
    mem_en        = (state_q == ISSUE);
    mem_addr      = addr_q;
    mem_wdata     = mem_en ? wdata_q : '0;
    mem_wstrb     = mem_en ? wstrb_q : '0;
    if_resp_valid = (state_q == RESP) && (owner_q == OWN_IF) && !killed_q && !if_kill;
    if_resp_data  = if_resp_valid ? rdata_q : '0;
    d_resp_valid  = (state_q == RESP) && (owner_q == OWN_D);
    d_resp_data   = d_resp_valid ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiters (latency 1 and 3) share stimulus; the one selected
// by sel is checked against a response scoreboard and per-cycle port checks.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_kill, d_req_valid;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;

  logic [1:0]  if_rdy, if_rv, d_rdy, d_rv, men;
  logic [31:0] if_rd [2];
  logic [31:0] d_rd  [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd   [2];
  logic [31:0] mrd   [2];
  logic [3:0]  mws   [2];

  logic [31:0] m1_q;
  logic [31:0] m3_q [3];

  bit          sel;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          en_cnt = 0;
  exp_t        sbq [$];
  exp_t        mon_e;
  logic [31:0] mon_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_rdy[0]), .if_addr(if_addr), .if_kill(if_kill),
    .if_resp_valid(if_rv[0]), .if_resp_data(if_rd[0]),
    .d_req_valid(d_req_valid), .d_req_ready(d_rdy[0]), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_resp_valid(d_rv[0]), .d_resp_data(d_rd[0]),
    .mem_en(men[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_wstrb(mws[0]), .mem_rdata(mrd[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_rdy[1]), .if_addr(if_addr), .if_kill(if_kill),
    .if_resp_valid(if_rv[1]), .if_resp_data(if_rd[1]),
    .d_req_valid(d_req_valid), .d_req_ready(d_rdy[1]), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_resp_valid(d_rv[1]), .d_resp_data(d_rd[1]),
    .mem_en(men[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_wstrb(mws[1]), .mem_rdata(mrd[1])
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Memory models: data appears MEM_LATENCY cycles after mem_en, garbage otherwise.
  always @(posedge clk) begin
    m1_q    <= men[0] ? memf(maddr[0]) : 32'hBAD0_BAD0;
    m3_q[0] <= men[1] ? memf(maddr[1]) : 32'hBAD0_BAD0;
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign mrd[0] = m1_q;
  assign mrd[1] = m3_q[2];

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    if (men[sel]) en_cnt++;
    if (if_rv[sel] || d_rv[sel]) begin
      vectors++;
      assert (sbq.size() != 0) else begin
        miscompares++;
        $error("FAIL resp_unexpected: observed if_resp_valid=%b d_resp_valid=%b at cycle %0d, required none",
               if_rv[sel], d_rv[sel], cyc);
      end
      if (sbq.size() != 0) begin
        mon_e    = sbq.pop_front();
        mon_data = d_rv[sel] ? d_rd[sel] : if_rd[sel];
        vectors++;
        assert ({if_rv[sel], d_rv[sel], mon_data} === {~mon_e.is_d, mon_e.is_d, mon_e.data}) else begin
          miscompares++;
          $error("FAIL resp_data: observed if/d=%b%b data=%h, required if/d=%b%b data=%h",
                 if_rv[sel], d_rv[sel], mon_data, ~mon_e.is_d, mon_e.is_d, mon_e.data);
        end
        vectors++;
        assert (cyc == mon_e.due) else begin
          miscompares++;
          $error("FAIL resp_cycle: observed cycle %0d, required cycle %0d", cyc, mon_e.due);
        end
      end
    end
    if (sbq.size() != 0) begin
      vectors++;
      assert (cyc <= sbq[0].due) else begin
        miscompares++;
        $error("FAIL resp_missing: observed none by cycle %0d, required response at cycle %0d", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input bit is_d, input logic [31:0] a, input logic [3:0] ws, input int t);
    exp_t e;
    bit   store;
    store  = is_d && (ws != 4'h0);
    e.is_d = is_d;
    e.data = store ? 32'h0 : memf(a);
    e.due  = t + 2 + (store ? 0 : (sel ? 3 : 1));
    sbq.push_back(e);
  endtask

  // Raise a request and wait (bounded) for its handshake; returns at the sample point of T.
  task automatic issue(input bit is_d, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input bit exp_resp, output int t);
    bit got;
    got = 1'b0;
    t   = -1;
    if (is_d) begin
      d_req_valid = 1'b1; d_addr = a; d_wdata = wd; d_wstrb = ws;
    end else begin
      if_req_valid = 1'b1; if_addr = a;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      smp();
      if (is_d ? d_rdy[sel] : if_rdy[sel]) begin
        got = 1'b1;
        t   = cyc;
      end else begin
        step();
      end
    end
    vectors++;
    assert (got) else begin
      miscompares++;
      $error("FAIL handshake_timeout: observed no ready for addr %h, required ready within 40 cycles", a);
    end
    if (got && exp_resp) push_exp(is_d, a, ws, t);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({if_rdy[sel], if_rv[sel], d_rdy[sel], d_rv[sel], men[sel], mws[sel]}), 64'h0);
    chk({tag, "_bus"}, 64'(if_rd[sel] | d_rd[sel] | maddr[sel] | mwd[sel]), 64'h0);
  endtask

  task automatic do_reset(input bit s);
    rst_n = 1'b0;
    if_req_valid = 1'b0; if_kill = 1'b0; if_addr = 32'h0;
    d_req_valid = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
    sel = s;
    sbq.delete();
    step();
    step();
    smp();
    chk_zero("reset");
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 60 && sbq.size() != 0; i++) step();
    vectors++;
    assert (sbq.size() == 0) else begin
      miscompares++;
      $error("FAIL drain_timeout: observed %0d pending responses, required 0", sbq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish within 200000 time units");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t, t2, grants, e0;
    bit exp_d;

    // Contention after reset: data wins first, then fetch in the RESP cycle.
    do_reset(1'b0);
    if_req_valid = 1'b1; if_addr = 32'h100;
    issue(1'b1, 32'h200, 32'h0, 4'h0, 1'b1, t);
    chk("first_grant_if_ready", 64'(if_rdy[sel]), 64'h0);
    step();
    d_req_valid = 1'b0;
    smp();
    chk("ld_issue_en", 64'(men[sel]), 64'h1);
    chk("ld_issue_addr", 64'(maddr[sel]), 64'h200);
    chk("ld_issue_if_ready", 64'(if_rdy[sel]), 64'h0);
    step();
    smp();
    chk("ld_wait_en", 64'(men[sel]), 64'h0);
    step();
    issue(1'b0, 32'h100, 32'h0, 4'h0, 1'b1, t2);
    chk("fetch_grant_cycle", 64'(t2 - t), 64'h3);
    step();
    if_req_valid = 1'b0;
    smp();
    chk("fetch_issue_en", 64'(men[sel]), 64'h1);
    chk("fetch_issue_addr", 64'(maddr[sel]), 64'h100);
    wait_empty();

    // Partial-strobe store.
    do_reset(1'b0);
    issue(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 1'b1, t);
    step();
    d_req_valid = 1'b0;
    smp();
    chk("st_issue_en", 64'(men[sel]), 64'h1);
    chk("st_issue_wstrb", 64'(mws[sel]), 64'h3);
    chk("st_issue_wdata", 64'(mwd[sel]), 64'hDEAD_BEEF);
    chk("st_issue_addr", 64'(maddr[sel]), 64'h40);
    step();
    smp();
    chk("st_after_issue", 64'({men[sel], mws[sel], mwd[sel]}), 64'h0);
    wait_empty();

    // Both requesters continuously valid: grants alternate D, IF, D, ...
    do_reset(1'b0);
    if_req_valid = 1'b1; if_addr = 32'h180;
    d_req_valid = 1'b1; d_addr = 32'h300; d_wdata = 32'h0; d_wstrb = 4'h0;
    grants = 0;
    exp_d  = 1'b1;
    for (int i = 0; i < 200 && grants < 10; i++) begin
      smp();
      if (if_rdy[sel] || d_rdy[sel]) begin
        chk("alt_grant", 64'({d_rdy[sel], if_rdy[sel]}), exp_d ? 64'h2 : 64'h1);
        push_exp(d_rdy[sel], d_rdy[sel] ? 32'h300 : 32'h180, 4'h0, cyc);
        grants++;
        exp_d = !exp_d;
      end
      step();
    end
    chk("alt_grant_count", 64'(grants), 64'd10);
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    wait_empty();

    // Latency 3: back-to-back fetches, one mem_en cycle each.
    do_reset(1'b1);
    e0 = en_cnt;
    issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, t);
    step();
    issue(1'b0, 32'h4, 32'h0, 4'h0, 1'b1, t2);
    chk("b2b_gap", 64'(t2 - t), 64'd5);
    step();
    if_req_valid = 1'b0;
    wait_empty();
    chk("b2b_mem_en_cycles", 64'(en_cnt - e0), 64'd2);

    // Kill during WAIT suppresses the fetch; next fetch accepted in RESP.
    do_reset(1'b1);
    issue(1'b0, 32'h8, 32'h0, 4'h0, 1'b0, t);
    step();
    if_req_valid = 1'b0;
    step();
    step();
    if_kill = 1'b1;
    smp();
    step();
    if_kill = 1'b0;
    issue(1'b0, 32'hC, 32'h0, 4'h0, 1'b1, t2);
    chk("kill_next_accept", 64'(t2 - t), 64'd5);
    step();
    if_req_valid = 1'b0;
    wait_empty();

    // Reset while a load is in WAIT: abandoned, then a fresh load completes.
    do_reset(1'b1);
    issue(1'b1, 32'h500, 32'h0, 4'h0, 1'b1, t);
    step();
    d_req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    sbq.delete();
    step();
    smp();
    chk_zero("midreset");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    issue(1'b1, 32'h600, 32'h0, 4'h0, 1'b1, t);
    step();
    d_req_valid = 1'b0;
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the instruction-fetch requester and the load/store requester of the processor core.
- Together with a small core-side sequencer, it replaces the separate instruction and data memory instances.
- Each requester uses a valid/ready request channel and a one-cycle response pulse.
- Alternating priority under contention guarantees that neither requester starves.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data width. The byte-strobe width is DATA_W/8.
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata. Legal range is 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- if_req_valid  in  1  fetch request pending.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  ADDR_W  fetch address.
- if_kill  in  1  discard the outstanding fetch response (redirect).
- if_resp_valid  out  1  fetch data valid; one-cycle pulse.
- if_resp_data  out  DATA_W  fetched word.
- d_req_valid  in  1  data request pending.
- d_req_ready  out  1  data request accepted this cycle.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wstrb  in  DATA_W/8  byte strobes; zero means a load.
- d_resp_valid  out  1  load data or store completion; one-cycle pulse.
- d_resp_data  out  DATA_W  load word; zero for stores.
- mem_en  out  1  memory access strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wstrb  out  DATA_W/8  memory byte-write enables; zero means a read.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE and the priority bit is set to data-first.
  - All outputs are 0, including ready, resp_valid, mem_en, mem_wstrb and the data buses.
  - A reset mid-transaction abandons that transaction: no response is issued and mem_en is not re-asserted.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE and RESP are accept states. In an accept state:
  - Grant is computed combinationally from the valids and the priority bit.
  - Only the granted requester's ready is high, and only while its valid is high.
  - On a handshake, the address, wdata, wstrb and owner are captured into registers and the FSM moves to ISSUE.
  - With no valid request, the FSM goes to IDLE.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the priority holder is granted.
  - After every grant, the priority bit points to the other requester.
- ISSUE (exactly one cycle):
  - mem_en = 1, and mem_addr, mem_wdata and mem_wstrb are driven from the captured registers.
  - A store (wstrb ≠ 0) goes directly to RESP.
  - A load or fetch loads a counter with MEM_LATENCY and goes to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - When it reaches 1, mem_rdata is sampled into the response register and the FSM goes to RESP.
  - MEM_LATENCY = 1 means a single WAIT cycle.
- RESP (one cycle):
  - The owner's resp_valid = 1 and resp_data comes from the registered sample.
  - The other requester's resp_valid stays 0.
  - A new request may be accepted in the same cycle.
- mem_en, mem_wstrb and mem_wdata are 0 outside ISSUE. mem_addr holds its last value.
- Latency, with a handshake in cycle T:
  - Load/fetch: mem_en in T+1, resp_valid in T+2+MEM_LATENCY.
  - Store: mem_en in T+1, resp_valid in T+2.
  - Maximum throughput is one access per MEM_LATENCY+2 cycles for loads and one per 2 cycles for stores.
- if_kill:
  - If if_kill is high in any cycle while a fetch is owned and not yet responded (ISSUE, WAIT, or the RESP cycle itself), that response is suppressed: if_resp_valid stays 0.
  - A kill does not alter FSM timing; the memory access still completes.
  - if_kill in IDLE, or while a data access is owned, has no effect.
- A request whose valid drops before ready is not an error; nothing is captured.
- Requesters hold valid and payload stable until ready. The block does not check this.

Decomposition:
- Package mem_port_arbiter_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the owner encoding (OWN_IF = 0, OWN_D = 1);
  - the latency counter width (4).
- One sub-module, rr_arb2: a 2-requester alternating-priority grant with a registered priority bit and an update enable. It is reusable for future shared ports.

Test Plan:
- Reset, then both valids high in the same cycle, if_addr = 0x100, d_addr = 0x200 load, MEM_LATENCY = 1:
  - d_req_ready is high first; mem_en with addr 0x200 in T+1; d_resp_valid in T+3 with mem_rdata.
  - if_req_ready goes high in T+3; mem_en with addr 0x100 in T+4.
- Store d_addr = 0x40, d_wdata = 0xDEADBEEF, d_wstrb = 4'b0011:
  - mem_en in T+1 with mem_wstrb = 0011; d_resp_valid in T+2 with data 0.
  - No if_resp_valid.
- MEM_LATENCY = 3, back-to-back fetches 0x0, 0x4:
  - resp pulses 5 cycles apart, data matches the memory model.
  - mem_en is high for exactly one cycle per access.
- if_kill during WAIT for fetch 0x8:
  - No if_resp_valid.
  - The next fetch is accepted in the RESP cycle and returns correct data.
- Both requesters continuously valid for 10 grants: grants strictly alternate D, IF, D, IF…
- rst_n low during WAIT:
  - All outputs are 0 the next cycle and no response pulses.
  - After release, a new load completes normally.
